// File: rtl/cl2_csr_reg_pkg.sv
// cl2_csr_reg_pkg
//   Shared CSR-side definitions for the cl2 interrupt controller:
//   - cl2_csr_mip_reg_t / cl2_csr_mie_reg_t : bit layouts of mip and mie
//   - IRQ_CAUSE_* : machine interrupt exception codes
//   - IRQ_PRIO    : causes listed highest priority first
//   - cl2_irq_state_e : request/acknowledge FSM states
//   - irq_pick()  : highest-priority cause present in a pending word
// No ports; imported by cl2_irq_ctrl.
package cl2_csr_reg_pkg;

  typedef struct packed {
    logic [17:0] zero_31_14;
    logic        lcofip;     // 13
    logic        zero_12;
    logic        meip;       // 11
    logic        zero_10;
    logic        seip;       // 9
    logic        zero_8;
    logic        mtip;       // 7
    logic        zero_6;
    logic        stip;       // 5
    logic        zero_4;
    logic        msip;       // 3
    logic        zero_2;
    logic        ssip;       // 1
    logic        zero_0;
  } cl2_csr_mip_reg_t;

  typedef struct packed {
    logic [17:0] zero_31_14;
    logic        lcofie;
    logic        zero_12;
    logic        meie;
    logic        zero_10;
    logic        seie;
    logic        zero_8;
    logic        mtie;
    logic        zero_6;
    logic        stie;
    logic        zero_4;
    logic        msie;
    logic        zero_2;
    logic        ssie;
    logic        zero_0;
  } cl2_csr_mie_reg_t;

  localparam logic [4:0] IRQ_CAUSE_SSI   = 5'd1;
  localparam logic [4:0] IRQ_CAUSE_MSI   = 5'd3;
  localparam logic [4:0] IRQ_CAUSE_STI   = 5'd5;
  localparam logic [4:0] IRQ_CAUSE_MTI   = 5'd7;
  localparam logic [4:0] IRQ_CAUSE_SEI   = 5'd9;
  localparam logic [4:0] IRQ_CAUSE_MEI   = 5'd11;
  localparam logic [4:0] IRQ_CAUSE_LCOFI = 5'd13;

  localparam int IRQ_NUM = 7;

  // Highest priority first.
  localparam logic [4:0] IRQ_PRIO [IRQ_NUM] = '{
    IRQ_CAUSE_MEI, IRQ_CAUSE_MSI, IRQ_CAUSE_MTI, IRQ_CAUSE_SEI,
    IRQ_CAUSE_SSI, IRQ_CAUSE_STI, IRQ_CAUSE_LCOFI
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    TAKEN = 2'd2
  } cl2_irq_state_e;

  // Returns the code of the highest-priority set bit; 0 if none is set.
  function automatic logic [4:0] irq_pick(input logic [31:0] pend);
    logic [4:0] cause;
    logic       found;
    cause = '0;
    found = 1'b0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (!found && pend[IRQ_PRIO[i]]) begin
        cause = IRQ_PRIO[i];
        found = 1'b1;
      end
    end
    return cause;
  endfunction

endpackage

// File: rtl/cl2_irq_sync.sv
// cl2_irq_sync
//   1-bit two-flop synchronizer, asynchronous active-low reset to 0.
// Ports:
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronized output (second flop)
module cl2_irq_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cl2_irq_ctrl.sv
// cl2_irq_ctrl
//   Machine-level interrupt controller for the cl2 core. Builds the
//   architectural mip value from the external lines, the counter-overflow
//   flag and software-written supervisor bits, gates it with mie, the
//   global enable and privilege, and raises one prioritised request with
//   its cause over a request/acknowledge handshake.
//   Build option: CL2_IRQ_SYNC_EN -- when defined, meip/mtip/msip pass
//   through two-flop synchronizers (2-clock latency); otherwise they are
//   captured by a single register (1-clock latency, synchronous inputs).
// Ports:
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   meip_i/mtip_i/msip_i: external interrupt lines
//   lcofip_i            : counter-overflow flag (synchronous)
//   mip_we_i/mip_wdata_i: software write of mip (ssip/stip/seip only)
//   mie_i, mstatus_mie_i, priv_i : enable word, global enable, privilege
//   mip_o               : architectural mip
//   irq_req_o/irq_cause_o/irq_ack_i : request handshake to trap logic
//   wake_o              : WFI wake (pending & enabled, ignores global enable)
module cl2_irq_ctrl
  import cl2_csr_reg_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               meip_i,
  input  logic               mtip_i,
  input  logic               msip_i,
  input  logic               lcofip_i,
  input  logic               mip_we_i,
  input  logic [XLEN-1:0]    mip_wdata_i,
  input  logic [XLEN-1:0]    mie_i,
  input  logic               mstatus_mie_i,
  input  logic [1:0]         priv_i,
  output logic [XLEN-1:0]    mip_o,
  output logic               irq_req_o,
  output logic [CAUSE_W-1:0] irq_cause_o,
  input  logic               irq_ack_i,
  output logic               wake_o
);

  // {meip, mtip, msip} as seen by mip
  logic [2:0] hw_lines;

`ifdef CL2_IRQ_SYNC_EN
  // The synchronizer's second flop is the mip storage for these bits.
  cl2_irq_sync u_sync_meip (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (meip_i),
    .q_o     (hw_lines[2])
  );
  cl2_irq_sync u_sync_mtip (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (mtip_i),
    .q_o     (hw_lines[1])
  );
  cl2_irq_sync u_sync_msip (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (msip_i),
    .q_o     (hw_lines[0])
  );
`else
  logic [2:0] hw_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hw_q <= '0;
    end else begin
      hw_q <= {meip_i, mtip_i, msip_i};
    end
  end

  assign hw_lines = hw_q;
`endif

  // Counter-overflow flag and software-owned supervisor bits.
  logic lcofip_q;
  logic ssip_q, ssip_d;
  logic stip_q, stip_d;
  logic seip_q, seip_d;

  always_comb begin
    ssip_d = ssip_q;
    stip_d = stip_q;
    seip_d = seip_q;
    if (mip_we_i) begin
      ssip_d = mip_wdata_i[1];
      stip_d = mip_wdata_i[5];
      seip_d = mip_wdata_i[9];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lcofip_q <= 1'b0;
      ssip_q   <= 1'b0;
      stip_q   <= 1'b0;
      seip_q   <= 1'b0;
    end else begin
      lcofip_q <= lcofip_i;
      ssip_q   <= ssip_d;
      stip_q   <= stip_d;
      seip_q   <= seip_d;
    end
  end

  // Only bits 1, 5 and 9 of the write data are architecturally writable.
  logic unused_wdata;
  assign unused_wdata = ^{mip_wdata_i[XLEN-1:10], mip_wdata_i[8:6],
                          mip_wdata_i[4:2], mip_wdata_i[0]};

  cl2_csr_mip_reg_t mip_s;

  always_comb begin
    mip_s        = '0;
    mip_s.meip   = hw_lines[2];
    mip_s.mtip   = hw_lines[1];
    mip_s.msip   = hw_lines[0];
    mip_s.lcofip = lcofip_q;
    mip_s.ssip   = ssip_q;
    mip_s.stip   = stip_q;
    mip_s.seip   = seip_q;
  end

  assign mip_o = XLEN'(mip_s);

  logic [31:0] pend;
  logic        gie;

  assign pend   = mip_s & mie_i[31:0];
  assign gie    = (priv_i != 2'b11) | mstatus_mie_i;
  assign wake_o = |pend;

  // Request FSM
  cl2_irq_state_e state_q, state_d;
  logic [4:0]     cause_q, cause_d;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      // TAKEN spends its one cycle with the request low, then evaluates
      // exactly as IDLE does, so a still-pending source re-requests after
      // a single dead cycle and sees the updated mstatus.MIE.
      IDLE, TAKEN: begin
        state_d = IDLE;
        if (gie && (|pend)) begin
          state_d = REQ;
          cause_d = irq_pick(pend);
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = TAKEN;
        end else if (!gie || !pend[cause_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign irq_req_o   = (state_q == REQ);
  assign irq_cause_o = CAUSE_W'(cause_q);

endmodule

// File: tb/tb_cl2_irq_ctrl.sv
module tb_cl2_irq_ctrl;

`ifdef CL2_IRQ_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meip = 1'b0, mtip = 1'b0, msip = 1'b0, lcofip = 1'b0;
  logic        mip_we = 1'b0;
  logic [31:0] mip_wdata = '0;
  logic [31:0] mie = '0;
  logic        mstatus_mie = 1'b0;
  logic [1:0]  priv = 2'b11;
  logic [31:0] mip_o;
  logic        irq_req;
  logic [4:0]  irq_cause;
  logic        irq_ack = 1'b0;
  logic        wake;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cl2_irq_ctrl #(.XLEN(32), .CAUSE_W(5)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .meip_i        (meip),
    .mtip_i        (mtip),
    .msip_i        (msip),
    .lcofip_i      (lcofip),
    .mip_we_i      (mip_we),
    .mip_wdata_i   (mip_wdata),
    .mie_i         (mie),
    .mstatus_mie_i (mstatus_mie),
    .priv_i        (priv),
    .mip_o         (mip_o),
    .irq_req_o     (irq_req),
    .irq_cause_o   (irq_cause),
    .irq_ack_i     (irq_ack),
    .wake_o        (wake)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Interrupt priority list, highest first, as exception codes.
  int prio [7] = '{11, 3, 7, 9, 1, 5, 13};
  // Line history: hist[k] = {meip,mtip,msip} seen k+1 edges ago.
  logic [2:0]  hist [2];
  logic [31:0] m_mip = '0;
  logic        m_ssip = 0, m_stip = 0, m_seip = 0, m_lcof = 0;
  bit          m_req = 0;
  int          m_cause = 0;

  function automatic int top_cause(input logic [31:0] p);
    for (int i = 0; i < 7; i++)
      if (p[prio[i]]) return prio[i];
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist[0] = '0; hist[1] = '0;
      m_ssip = 0; m_stip = 0; m_seip = 0; m_lcof = 0;
      m_mip = '0; m_req = 0; m_cause = 0;
    end else begin
      logic [31:0] p;
      bit g;
      p = m_mip & mie;
      g = (priv != 2'b11) || mstatus_mie;
      if (m_req) begin
        if (irq_ack) m_req = 0;
        else if (!g || !p[m_cause]) m_req = 0;
      end else if (g && p != 0) begin
        m_req = 1;
        m_cause = top_cause(p);
      end
      hist[1] = hist[0];
      hist[0] = {meip, mtip, msip};
      if (mip_we) begin
        m_ssip = mip_wdata[1]; m_stip = mip_wdata[5]; m_seip = mip_wdata[9];
      end
      m_lcof = lcofip;
      m_mip = '0;
      m_mip[11] = hist[L-1][2];
      m_mip[7]  = hist[L-1][1];
      m_mip[3]  = hist[L-1][0];
      m_mip[13] = m_lcof;
      m_mip[1]  = m_ssip;
      m_mip[5]  = m_stip;
      m_mip[9]  = m_seip;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("mdl_mip", mip_o, m_mip);
      check("mdl_req", {31'b0, irq_req}, {31'b0, m_req});
      if (m_req) check("mdl_cause", {27'b0, irq_cause}, 32'(m_cause));
      check("mdl_wake", {31'b0, wake}, {31'b0, |(m_mip & mie)});
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset with meip high
    meip = 1; mie = 32'h800; mstatus_mie = 1; priv = 2'b11;
    tick(3);
    check("rst_mip", mip_o, 32'h0);
    check("rst_req", {31'b0, irq_req}, 32'h0);
    check("rst_cause", {27'b0, irq_cause}, 32'h0);
    check("rst_wake", {31'b0, wake}, 32'h0);
    rst_n = 1;
    for (int k = 1; k <= L + 1; k++) begin
      tick();
      check("rel_mip11", {31'b0, mip_o[11]}, {31'b0, k >= L});
      check("rel_req", {31'b0, irq_req}, {31'b0, k > L});
    end
    check("rel_cause", {27'b0, irq_cause}, 32'd11);

    // Ack timing: one dead cycle, then re-request of the still-pending source
    irq_ack = 1;
    tick();
    irq_ack = 0;
    check("ack_low", {31'b0, irq_req}, 32'h0);
    tick();
    check("ack_rereq", {31'b0, irq_req}, 32'h1);
    check("ack_cause", {27'b0, irq_cause}, 32'd11);
    meip = 0;
    tick(L + 2);
    check("mei_drop_req", {31'b0, irq_req}, 32'h0);
    check("mei_drop_mip", mip_o, 32'h0);

    // Priority: MSI beats MTI beats LCOFI
    mie = 32'h2888; mtip = 1; msip = 1;
    if (L > 1) tick(L - 1);
    lcofip = 1;
    tick();
    check("pri_mip", mip_o, 32'h2088);
    tick();
    check("pri_req", {31'b0, irq_req}, 32'h1);
    check("pri_cause3", {27'b0, irq_cause}, 32'd3);
    irq_ack = 1; msip = 0;
    tick();
    irq_ack = 0; mstatus_mie = 0;
    check("pri_taken", {31'b0, irq_req}, 32'h0);
    tick(L + 1);
    check("pri_mip2", mip_o, 32'h2080);
    mstatus_mie = 1;
    tick();
    check("pri_cause7", {27'b0, irq_cause}, 32'd7);
    check("pri_req7", {31'b0, irq_req}, 32'h1);
    irq_ack = 1; mtip = 0;
    tick();
    irq_ack = 0; mstatus_mie = 0;
    tick(L + 1);
    check("pri_mip3", mip_o, 32'h2000);
    mstatus_mie = 1;
    tick();
    check("pri_cause13", {27'b0, irq_cause}, 32'd13);
    irq_ack = 1; lcofip = 0;
    tick();
    irq_ack = 0; mstatus_mie = 0;
    tick(L + 1);

    // Withdrawal without ack
    mstatus_mie = 1; mie = 32'h80; mtip = 1;
    tick(L + 1);
    check("wd_req", {31'b0, irq_req}, 32'h1);
    check("wd_cause", {27'b0, irq_cause}, 32'd7);
    mtip = 0;
    tick(L);
    check("wd_mip7", {31'b0, mip_o[7]}, 32'h0);
    check("wd_req_hold", {31'b0, irq_req}, 32'h1);
    tick();
    check("wd_req_drop", {31'b0, irq_req}, 32'h0);

    // Ack outside REQ is ignored
    irq_ack = 1;
    tick(2);
    check("ack_idle", {31'b0, irq_req}, 32'h0);
    irq_ack = 0;

    // Global gating
    priv = 2'b11; mstatus_mie = 0; mie = 32'h8; msip = 1;
    tick(L + 2);
    check("gie_req", {31'b0, irq_req}, 32'h0);
    check("gie_wake", {31'b0, wake}, 32'h1);
    priv = 2'b00;
    tick();
    check("gie_umode_req", {31'b0, irq_req}, 32'h1);
    check("gie_umode_cause", {27'b0, irq_cause}, 32'd3);
    priv = 2'b11; msip = 0;
    tick(L + 2);
    check("gie_off", {31'b0, irq_req}, 32'h0);

    // Software bits
    mie = 32'h0; mip_we = 1; mip_wdata = 32'hFFFF_FFFF;
    tick();
    mip_we = 0;
    check("sw_mip", mip_o, 32'h0000_0222);
    mie = 32'h200; mstatus_mie = 1;
    tick();
    check("sw_req", {31'b0, irq_req}, 32'h1);
    check("sw_cause", {27'b0, irq_cause}, 32'd9);
    // Write and hardware update in the same cycle
    mip_we = 1; mip_wdata = 32'h0; lcofip = 1; mie = 32'h0;
    tick();
    mip_we = 0;
    check("sw_hw_mix", mip_o, 32'h0000_2000);
    tick(3);

    // Asynchronous reset mid-handshake
    mie = 32'h2000;
    tick(2);
    check("arst_pre", {31'b0, irq_req}, 32'h1);
    #2 rst_n = 0;
    #1;
    check("arst_req", {31'b0, irq_req}, 32'h0);
    check("arst_mip", mip_o, 32'h0);
    tick(2);
    lcofip = 0;
    rst_n = 1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cl2_irq_ctrl.md
# cl2_irq_ctrl

Machine-level interrupt controller for the cl2 core, sitting directly upstream of the CSR file. It samples the external interrupt lines and the counter-overflow flag, maintains the architectural `mip` value and applies the software writes to `mip`. It gates pending bits with `mie`, the global enable and the current privilege, and presents one prioritised interrupt request with its cause to the pipeline's trap logic over a request/acknowledge handshake.

## Interface
- `XLEN`, 32, width of the `mip`/`mie` CSR words.
- `CAUSE_W`, 5, width of the exception-code field.

Ports:
- `clk_i` in 1: core clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `meip_i` in 1: machine external interrupt line, asynchronous to `clk_i`.
- `mtip_i` in 1: machine timer interrupt line, asynchronous.
- `msip_i` in 1: machine software interrupt line, asynchronous.
- `lcofip_i` in 1: local counter-overflow flag, synchronous to `clk_i`.
- `mip_we_i` in 1: CSR write strobe for `mip`.
- `mip_wdata_i` in XLEN: `mip` write data.
- `mie_i` in XLEN: current `mie`, in the `cl2_csr_mie_reg_t` layout.
- `mstatus_mie_i` in 1: `mstatus.MIE`.
- `priv_i` in 2: current privilege; 2'b11 = M.
- `mip_o` out XLEN: architectural `mip`, in the `cl2_csr_mip_reg_t` layout.
- `irq_req_o` out 1: interrupt request to the trap logic.
- `irq_cause_o` out CAUSE_W: exception code, valid while `irq_req_o` is high.
- `irq_ack_i` in 1: the trap logic has taken the request this cycle.
- `wake_o` out 1: WFI wake-up; pending AND enabled, ignoring the global enable.

## Operation
- **Hardware bits.** `meip`, `mtip`, `msip` and `lcofip` follow their inputs through the sampling path. A CSR write to these bits has no effect.
- **Software bits.** `ssip`, `stip` and `seip` are registers written only via `mip_we_i`, taking bits 1, 5 and 9 of `mip_wdata_i`.
- **Fixed-zero bits.** All other bits of `mip_o` read 0.
- **Enabled pending set.** `pend = mip_o & mie_i`.
- **Global enable.** `gie = (priv_i != 2'b11) | mstatus_mie_i`. All interrupts are taken to M-mode; there is no delegation.
- **Priority**, highest first: MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5), LCOFI(13). The cause is the code of the highest set bit of `pend`.
- **FSM states.**
  - IDLE: if `gie & |pend`, latch the cause and go to REQ.
  - REQ: `irq_req_o` = 1 and `irq_cause_o` held stable.
    - `irq_ack_i` → TAKEN.
    - Otherwise, if `gie` = 0 or the latched cause's bit is no longer in `pend` → IDLE, request withdrawn.
    - A newly pending interrupt of higher priority does not replace the latched cause; it is presented after the current one is resolved.
  - TAKEN: one cycle with `irq_req_o` = 0, then IDLE. This lets the CSR file clear `mstatus.MIE` before re-evaluation.
- **`irq_ack_i` outside REQ** is ignored.
- **Write versus hardware update:** a software write and a hardware update in the same cycle touch disjoint bits; both take effect.
- **Reset values:** `mip_o` = 0, `irq_req_o` = 0, `irq_cause_o` = 0, `wake_o` = 0, FSM = IDLE. Reset asserted mid-handshake drops the request immediately (asynchronous).

## Timing
- **Sampling latency, external lines:** 2 clocks from the first capturing edge to `mip_o` with `CL2_IRQ_SYNC_EN`, 1 clock without it.
- **Sampling latency, `lcofip_i`:** 1 clock in both builds.
- **Software write:** visible in `mip_o` the clock after `mip_we_i`.
- **Request latency:** `irq_req_o` rises 1 clock after `mip_o` shows an enabled bit while `gie` = 1.
- **Handshake:** the ack is taken on the clock edge where `irq_req_o` and `irq_ack_i` are both high. `irq_req_o` is low the following cycle (TAKEN).
- **`wake_o`:** combinational from registered `mip_o` and `mie_i`; no extra latency.

## Configuration
- `CL2_IRQ_SYNC_EN` defined:
  - `meip_i`, `mtip_i` and `msip_i` each pass through a two-flop synchronizer before the `mip` register.
  - The synchronizer flops reset to 0.
- Not defined:
  - The three lines are captured by a single register.
  - This build is for inputs already synchronous to `clk_i`.
- `lcofip_i` is never synchronized.

## Structure
- Shared package `cl2_csr_reg_pkg` holds:
  - the `cl2_csr_mip_reg_t` and `cl2_csr_mie_reg_t` structs;
  - the interrupt cause constants (`IRQ_CAUSE_MEI` = 11, `IRQ_CAUSE_MSI` = 3, etc.);
  - the FSM enum `cl2_irq_state_e` {IDLE, REQ, TAKEN}.
- Sub-module `cl2_irq_sync`: a 1-bit two-flop synchronizer with asynchronous active-low reset. It is instantiated three times under `CL2_IRQ_SYNC_EN`.

## Test plan
- **Reset:** hold `rst_n_i` low with `meip_i` = 1 → `mip_o` = 0 and `irq_req_o` = 0. After release, with the sync build: `mip_o[11]` = 1 on cycle 2, `irq_req_o` = 1 on cycle 3 when `mie_i` = 32'h800 and `mstatus_mie_i` = 1.
- **Priority:** `mie_i` = 32'h2888 with `mtip`, `msip` and `lcofip` raised together → `irq_cause_o` = 3. After ack, TAKEN, then re-request → cause 7 (`msip_i` dropped), then 13.
- **Withdrawal:** in REQ with cause 7, drop `mtip_i` before ack → `irq_req_o` falls once `mip_o[7]` clears; the FSM returns to IDLE with no ack.
- **Global gating:** `priv_i` = 3, `mstatus_mie_i` = 0, `msip` pending and enabled → `irq_req_o` stays 0 and `wake_o` = 1. Switch `priv_i` to 0 → request with cause 3 one cycle later.
- **Software bits:** `mip_we_i` with data 32'hFFFF_FFFF → `mip_o` = 32'h0000_0222 (hardware lines low). Then `mie_i` = 32'h200 with `gie` = 1 → cause 9.
- **Ack timing:** assert `irq_ack_i` with `irq_req_o` low → no state change. Ack in REQ → `irq_req_o` = 0 for exactly one cycle while the source is still pending, then reasserts.
